joy_db15_target: RTL and testbench
==================================

# joy_db15_target

Device-side model of the DB15 serial joystick adapter, a 74HC165-style parallel-in/serial-out chain. It answers the host's JOY_LOAD/JOY_CLK strobes with a 32-bit active-low bitstream on JOY_DATA, built from two 16-bit joystick words. It sits on the USER_IN/USER_OUT port path, either in loopback benches against the DB15 reader or in a bridge core that presents local controls as a DB15 adapter.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on each strobe input (min 2).
- FILTER_LEN, 2: consecutive equal synchronized samples needed before a strobe level is accepted (min 1).

Ports:
- clk  in  1  system clock, 40-50 MHz.
- reset  in  1  synchronous, active-high.
- joy_load  in  1  host load strobe, active-low, asynchronous pin.
- joy_clk  in  1  host shift clock; shifts on rising edge; asynchronous pin.
- joystick1  in  16  player-1 buttons, active-high: bits 3:0 = U D L R, bits 15:4 = buttons.
- joystick2  in  16  player-2 buttons, same layout.
- joy_data  out  1  serial data, active-low (0 = pressed); idles 1.
- frame_done  out  1  one-cycle pulse when the 32nd shift completes.
- short_frame  out  1  one-cycle pulse when a load aborts a frame with 0 < bit_cnt < 32.
- bit_cnt  out  6  shifts taken since the last load release, saturating at 32.

## Operation
- Conditioning:
  - Each strobe passes through SYNC_STAGES flops, then a glitch filter.
  - The filtered level updates only after FILTER_LEN consecutive synchronized samples differ from it.
  - Edges are detected on the filtered levels only.
- Frame word: frame[31:0] = {joystick2, joystick1}. It is shifted out LSB first, so joystick1[0] comes first and joystick2[15] comes last.
- Shift register: sr[31:0], active-high.
- Output: joy_data = ~sr[0], registered.
- State machine:
  - IDLE (after reset):
    - sr = 0, so joy_data = 1.
    - load low → LOAD.
    - joy_clk edges are ignored.
  - LOAD (load low):
    - sr <= frame every cycle (transparent parallel load).
    - bit_cnt <= 0.
    - joy_clk edges are ignored, because load dominates.
    - load rising → SHIFT. sr holds the frame sampled on the last LOAD cycle.
  - SHIFT (load high):
    - Each rising joy_clk edge: sr <= {1'b0, sr[31:1]}, bit_cnt += 1.
    - On the edge that takes bit_cnt from 31 to 32: pulse frame_done, go to DONE.
    - load low → LOAD. If 0 < bit_cnt < 32 at that moment, pulse short_frame.
  - DONE:
    - sr = 0, so joy_data = 1, like a tied-high serial input.
    - Further joy_clk edges: bit_cnt stays 32, no pulses.
    - load low → LOAD.
- Simultaneous load-fall and clk-rise in the same filtered cycle: load wins, no shift.
- Input changes:
  - joystick1/2 changes during SHIFT or DONE do not affect the current frame.
  - Changes during LOAD are tracked until the load release.

## Timing
- L = SYNC_STAGES + FILTER_LEN + 1 clocks from a strobe pin change to the resulting joy_data change. With defaults L = 5.
- frame_done and short_frame assert in the same cycle the state changes. joy_data reflects the new sr one cycle later.
- Host requirements:
  - Hold each strobe level ≥ FILTER_LEN + 1 clocks.
  - Sample joy_data ≥ L clocks after a load release or a clk rising edge.
- Pulses shorter than FILTER_LEN clocks after the synchronizer are rejected entirely.
- Reset values (including reset mid-frame):
  - state IDLE, sr 0, joy_data 1, frame_done 0, short_frame 0, bit_cnt 0.
  - Filtered load = 1, filtered clk = 0.
  - Synchronizer flops = the same inactive levels.
  - No edge is detected in the cycle reset deasserts.
- bit_cnt saturates at 32 and never wraps.

## Test plan
- Full frame: joystick1 = 16'h0005, joystick2 = 16'h8000, load pulse, then 32 clocks. Required:
  - joy_data after load = 0 (bit 0 pressed).
  - Sequence 0,1,0,1,1… with bit 31 = 0.
  - frame_done on the 32nd edge, bit_cnt = 32.
- Over-clocking: 40 clocks after a frame. Required: joy_data = 1 for edges 33-40, bit_cnt stays 32, a single frame_done.
- Abort: load again after 10 clocks. Required: short_frame pulse, bit_cnt = 0, joy_data = ~frame[0] of the fresh sample.
- Glitch: a 1-cycle high pulse on joy_clk during SHIFT. Required: no shift, bit_cnt unchanged.
- Latency: measure from a joy_clk pin rise to the joy_data change. Required: exactly 5 clocks with defaults.
- Reset mid-frame at bit_cnt = 17. Required:
  - All outputs at reset values next cycle.
  - joy_clk edges ignored until load.
  - Change joystick1 during SHIFT, then reload: the new frame carries the new value, while the old frame was unaffected.

Source files
------------

// File: rtl/joy_db15_target.sv
// joy_db15_target
// Device-side model of a DB15 serial joystick adapter, which behaves like a
// 74HC165-style parallel-in/serial-out chain. The host drives two strobes:
// JOY_LOAD (active-low) and JOY_CLK (shift on rising edge). The device answers
// with a 32-bit active-low bitstream built from two 16-bit joystick words.
//
// Ports:
//   clk          system clock (40-50 MHz)
//   reset        synchronous, active-high
//   joy_load     host load strobe, active-low, asynchronous pin
//   joy_clk      host shift clock, rising edge shifts, asynchronous pin
//   joystick1    player-1 controls, active-high (3:0 = U D L R, 15:4 = buttons)
//   joystick2    player-2 controls, same layout
//   joy_data     serial data, active-low, idles high
//   frame_done   one-cycle pulse when the 32nd shift completes
//   short_frame  one-cycle pulse when a load aborts a partially shifted frame
//   bit_cnt      shifts taken since the last load release, saturating at 32
module joy_db15_target #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_load,
    input  logic        joy_clk,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        joy_data,
    output logic        frame_done,
    output logic        short_frame,
    output logic [5:0]  bit_cnt
);

    // The filter counter only has to count up to FILTER_LEN-1 differing
    // samples; the FILTER_LEN-th one is the accepting sample itself.
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] load_sync, clk_sync;
    logic                   load_filt, clk_filt;
    logic [CW-1:0]          load_cnt, clk_cnt;
    logic                   load_raw, clk_raw;
    logic                   load_accept, clk_accept;
    logic                   load_fall, load_rise, clk_rise;

    logic [31:0] sr;
    logic        sr_load, sr_shift, sr_clear, done_set, short_set;

    // Synchronizer chains, reset to the inactive strobe levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_sync <= '1;
            clk_sync  <= '0;
        end else begin
            load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
        end
    end

    assign load_raw = load_sync[SYNC_STAGES-1];
    assign clk_raw  = clk_sync[SYNC_STAGES-1];

    // An accept marks the cycle in which the filtered level flips; the edge
    // strobes are taken from it directly so the FSM reacts in the same cycle
    // the filtered level changes.
    assign load_accept = (load_raw != load_filt) && (load_cnt == CMAX);
    assign clk_accept  = (clk_raw != clk_filt) && (clk_cnt == CMAX);
    assign load_fall   = load_accept & ~load_raw;
    assign load_rise   = load_accept & load_raw;
    assign clk_rise    = clk_accept & clk_raw;

    // Glitch filters: any synchronized sample equal to the current filtered
    // level restarts the run, so short pulses never reach the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_filt <= 1'b1;
            load_cnt  <= '0;
            clk_filt  <= 1'b0;
            clk_cnt   <= '0;
        end else begin
            if (load_raw == load_filt) begin
                load_cnt <= '0;
            end else if (load_accept) begin
                load_filt <= load_raw;
                load_cnt  <= '0;
            end else begin
                load_cnt <= load_cnt + CW'(1);
            end

            if (clk_raw == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_accept) begin
                clk_filt <= clk_raw;
                clk_cnt  <= '0;
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Load dominates everything: a load fall in any state restarts the frame.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_fall) next_state = LOAD;
            LOAD:    if (load_rise) next_state = SHIFT;
            SHIFT: begin
                if (load_fall)                             next_state = LOAD;
                else if (clk_rise && (bit_cnt == 6'd31))   next_state = DONE;
            end
            DONE:    if (load_fall) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Entering LOAD loads the frame on the same edge, so joy_data follows the
    // load fall with the same latency as a shift follows a clk rise.
    always_comb begin
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_clear  = 1'b0;
        done_set  = 1'b0;
        short_set = 1'b0;
        case (state)
            IDLE, DONE: begin
                sr_load  = load_fall;
                sr_clear = ~load_fall;
            end
            LOAD: sr_load = 1'b1;
            SHIFT: begin
                if (load_fall) begin
                    sr_load   = 1'b1;
                    short_set = (bit_cnt != 6'd0);
                end else if (clk_rise) begin
                    sr_shift = 1'b1;
                    done_set = (bit_cnt == 6'd31);
                end
            end
            default: sr_clear = 1'b1;
        endcase
    end

    // Shift register, counter and registered serial output.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr          <= '0;
            bit_cnt     <= '0;
            joy_data    <= 1'b1;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            frame_done  <= done_set;
            short_frame <= short_set;
            joy_data    <= ~sr[0];
            if (sr_load) begin
                sr      <= {joystick2, joystick1};
                bit_cnt <= '0;
            end else if (sr_shift) begin
                sr      <= {1'b0, sr[31:1]};
                bit_cnt <= (bit_cnt == 6'd32) ? bit_cnt : bit_cnt + 6'd1;
            end else if (sr_clear) begin
                sr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_joy_db15_target.sv
// tb_joy_db15_target
// Scoreboard bench for joy_db15_target. The stimulus process pushes expected
// serial-data/bit-count records and expected pulses into queues; a monitor
// process pops and compares whenever a sample is requested or the DUT emits
// frame_done / short_frame.
module tb_joy_db15_target;

    localparam int HOLD = 6;

    typedef struct {
        string name;
        logic  exp_data;
        int    exp_cnt;
    } data_rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        joy_load = 1'b1;
    logic        joy_clk = 1'b0;
    logic [15:0] joystick1 = '0;
    logic [15:0] joystick2 = '0;
    logic        joy_data;
    logic        frame_done;
    logic        short_frame;
    logic [5:0]  bit_cnt;

    logic        sample_req = 1'b0;
    data_rec_t   data_q[$];
    int          pulse_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    joy_db15_target dut (
        .clk         (clk),
        .reset       (reset),
        .joy_load    (joy_load),
        .joy_clk     (joy_clk),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .joy_data    (joy_data),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .bit_cnt     (bit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model of the serial output after k shifts of frame f.
    function automatic logic expData(input logic [31:0] f, input int k);
        if (k >= 32) return 1'b1;
        return ~f[k];
    endfunction

    // Drive both strobe pins and hold them for HOLD clocks.
    task automatic applyStimulus(input logic load_v, input logic clk_v);
        joy_load = load_v;
        joy_clk  = clk_v;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic clkPulse();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
    endtask

    // Queue an expectation and ask the monitor to sample once.
    task automatic checkOutput(input string name, input logic d, input int c);
        data_rec_t r;
        r.name = name;
        r.exp_data = d;
        r.exp_cnt = c;
        data_q.push_back(r);
        @(posedge clk);
        sample_req = 1'b1;
        @(posedge clk);
        sample_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares pulses as they appear and data on sample requests.
    always @(negedge clk) begin
        data_rec_t r;
        if (frame_done) begin
            vectors++;
            if (pulse_q.size() == 0 || pulse_q[0] != 1) begin
                miscompares++;
                $display("[TB] FAIL frame_done: unexpected pulse at bit_cnt=%0d", bit_cnt);
            end else begin
                void'(pulse_q.pop_front());
            end
        end
        if (short_frame) begin
            vectors++;
            if (pulse_q.size() == 0 || pulse_q[0] != 2) begin
                miscompares++;
                $display("[TB] FAIL short_frame: unexpected pulse at bit_cnt=%0d", bit_cnt);
            end else begin
                void'(pulse_q.pop_front());
            end
        end
        if (sample_req) begin
            vectors++;
            if (data_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL sample: no expectation queued");
            end else begin
                r = data_q.pop_front();
                if (joy_data !== r.exp_data || int'(bit_cnt) != r.exp_cnt) begin
                    miscompares++;
                    $display("[TB] FAIL %s: joy_data=%b bit_cnt=%0d, expected joy_data=%b bit_cnt=%0d",
                             r.name, joy_data, bit_cnt, r.exp_data, r.exp_cnt);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] f;
        logic        prev;
        int          n;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b1, 0);

        // Full frame followed by over-clocking.
        joystick1 = 16'h0005;
        joystick2 = 16'h8000;
        f = {joystick2, joystick1};
        applyStimulus(1'b0, 1'b0);
        checkOutput("loadLow", expData(f, 0), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("loadRelease", expData(f, 0), 0);

        prev = joy_data;
        joy_clk = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (joy_data !== prev) break;
        end
        checkValue("latency", n, 5);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b0);
        checkOutput("bit1", expData(f, 1), 1);

        for (int k = 2; k <= 40; k++) begin
            if (k == 32) pulse_q.push_back(1);
            clkPulse();
            checkOutput($sformatf("edge%0d", k), expData(f, k), (k > 32) ? 32 : k);
        end

        // Abort after 10 shifts; joystick change mid-shift must not leak in.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reload", expData(f, 0), 0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) joystick1 = 16'hFFFF;
            clkPulse();
        end
        checkOutput("shiftUnaffected", expData(f, 10), 10);

        joystick1 = 16'hFFFE;
        pulse_q.push_back(2);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abortLoad", 1'b1, 0);
        joystick1 = 16'h0001;
        applyStimulus(1'b0, 1'b0);
        checkOutput("loadTracks", 1'b0, 0);
        applyStimulus(1'b1, 1'b0);
        f = {joystick2, joystick1};
        checkOutput("abortRelease", expData(f, 0), 0);

        // One-cycle glitch on joy_clk must be rejected.
        joy_clk = 1'b1;
        @(negedge clk);
        joy_clk = 1'b0;
        repeat (HOLD) @(negedge clk);
        checkOutput("glitch", expData(f, 0), 0);
        clkPulse();
        checkOutput("postGlitch", expData(f, 1), 1);

        // Load fall and clk rise together: load wins.
        pulse_q.push_back(2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("simulLoad", expData(f, 0), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("simulRelease", expData(f, 0), 0);

        // Reset mid-frame at bit_cnt = 17 (load at bit_cnt 0: no short pulse).
        joystick1 = 16'h0005;
        joystick2 = 16'h0002;
        f = {joystick2, joystick1};
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 17; k++) clkPulse();
        checkOutput("preReset", expData(f, 17), 17);

        begin
            data_rec_t r;
            r.name = "resetMid";
            r.exp_data = 1'b1;
            r.exp_cnt = 0;
            data_q.push_back(r);
        end
        reset = 1'b1;
        @(posedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        sample_req = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 3; k++) clkPulse();
        checkOutput("clkIgnoredAfterReset", 1'b1, 0);

        joystick1 = 16'h0006;
        joystick2 = 16'h0000;
        f = {joystick2, joystick1};
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("newFrame", expData(f, 0), 0);
        clkPulse();
        checkOutput("newFrameBit1", expData(f, 1), 1);

        repeat (10) @(negedge clk);
        checkValue("pendingPulses", pulse_q.size(), 0);
        checkValue("pendingSamples", data_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
